// File: rtl/ws2811_pkg.sv
// ws2811_pkg
//   Shared constants for the WS2811 pattern provider family: colour width,
//   display mode encoding, wire colour-order selectors and the brightness
//   scaling helper used by every effect that drives the serialiser.
package ws2811_pkg;

    localparam int RGB_W = 24;

    typedef enum logic [1:0] {
        MODE_RAINBOW = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_OFF     = 2'd3
    } mode_t;

    localparam int ORDER_RGB = 0;
    localparam int ORDER_GRB = 1;

    // (c * (b + 1)) >> 8 : b = 255 leaves c untouched, b = 0 blanks it.
    // The product never exceeds 255 * 256, so 16 bits are enough.
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, b} + 16'd1);
        return 8'(p >> 8);
    endfunction

endpackage

// File: rtl/ws2811_color_wheel.sv
// ws2811_color_wheel
//   Combinational colour wheel: maps an 8-bit hue onto a fully saturated
//   {R,G,B} colour, fading R->G over 0..84, G->B over 85..169 and B->R
//   over 170..255.
// Ports:
//   hue  in   8       hue angle, 0..255
//   rgb  out  RGB_W   {R,G,B}
module ws2811_color_wheel
    import ws2811_pkg::*;
(
    input  logic [7:0]       hue,
    output logic [RGB_W-1:0] rgb
);

    logic [7:0] k;   // position inside the current third (0..85)
    logic [7:0] k3;  // 3*k, at most 255 so it fits in 8 bits

    always_comb begin
        k   = '0;
        k3  = '0;
        rgb = '0;
        if (hue < 8'd85) begin
            k   = hue;
            k3  = k + {k[6:0], 1'b0};
            rgb = {8'd255 - k3, k3, 8'd0};
        end else if (hue < 8'd170) begin
            k   = hue - 8'd85;
            k3  = k + {k[6:0], 1'b0};
            rgb = {8'd0, 8'd255 - k3, k3};
        end else begin
            k   = hue - 8'd170;
            k3  = k + {k[6:0], 1'b0};
            rgb = {k3, 8'd0, 8'd255 - k3};
        end
    end

endmodule

// File: rtl/ws2811_pattern_provider.sv
// ws2811_pattern_provider
//   Per-LED colour source for the WS2811 serialiser. The serialiser pulses
//   'advance' after consuming each LED and 'serial_reset' at frame end; this
//   block tracks the LED position and returns that LED's colour two clocks
//   after the index moves. Mode and brightness are captured only at frame
//   boundaries so a frame never mixes two settings.
// Ports:
//   clock         in   1       system clock
//   reset         in   1       asynchronous active-low reset
//   advance       in   1       rising edge: move to next LED (saturates)
//   serial_reset  in   1       rising edge: frame end, restart at LED 0
//   mode          in   2       RAINBOW / SOLID / CHASE / OFF
//   brightness    in   8       global scale, 255 = full
//   solid_rgb     in   RGB_W   {R,G,B} colour for SOLID and CHASE
//   rgb           out  RGB_W   current LED colour, wire order per ORDER
//   led_index     out  IDX_W   current LED index
//   last_led      out  1       led_index == NUM_LEDS-1
//   frame_count   out  16      completed frames, wrapping
module ws2811_pattern_provider
    import ws2811_pkg::*;
#(
    parameter  int NUM_LEDS   = 200,
    parameter  int HUE_SPREAD = 1,
    parameter  int PHASE_STEP = 1,
    parameter  int CHASE_LEN  = 4,
    parameter  int ORDER      = ORDER_RGB,
    localparam int IDX_W      = $clog2(NUM_LEDS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    input  logic             serial_reset,
    input  logic [1:0]       mode,
    input  logic [7:0]       brightness,
    input  logic [RGB_W-1:0] solid_rgb,
    output logic [RGB_W-1:0] rgb,
    output logic [IDX_W-1:0] led_index,
    output logic             last_led,
    output logic [15:0]      frame_count
);

    localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_LEDS - 1);
    localparam logic [IDX_W-1:0] LAST_M1 = IDX_W'(NUM_LEDS - 2);
    localparam logic [IDX_W:0]   NUM_W   = (IDX_W+1)'(NUM_LEDS);
    localparam logic [IDX_W:0]   CHASE_W = (IDX_W+1)'(CHASE_LEN);
    localparam logic [7:0]       PSTEP   = 8'(PHASE_STEP);

    // ---------------- edge detection ----------------
    logic adv_q, srst_q;
    logic adv_rise, srst_rise;

    assign adv_rise  = advance & ~adv_q;
    assign srst_rise = serial_reset & ~srst_q;

    // ---------------- counters and frame latches ----------------
    logic [7:0]       phase;
    logic [IDX_W-1:0] chase_pos;
    mode_t            mode_q;
    logic [7:0]       bright_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            adv_q       <= 1'b0;
            srst_q      <= 1'b0;
            led_index   <= '0;
            last_led    <= 1'b0;
            phase       <= '0;
            chase_pos   <= '0;
            frame_count <= '0;
            mode_q      <= MODE_RAINBOW;
            bright_q    <= 8'hFF;
        end else begin
            adv_q  <= advance;
            srst_q <= serial_reset;
            // Frame end takes priority; a coincident advance is discarded.
            if (srst_rise) begin
                led_index   <= '0;
                last_led    <= 1'b0;
                phase       <= phase + PSTEP;
                chase_pos   <= (chase_pos == LAST) ? '0 : chase_pos + 1'b1;
                frame_count <= frame_count + 16'd1;
                mode_q      <= mode_t'(mode);
                bright_q    <= brightness;
            end else if (adv_rise && led_index != LAST) begin
                led_index <= led_index + 1'b1;
                last_led  <= (led_index == LAST_M1);
            end
        end
    end

    // ---------------- stage 1: base colour ----------------
    logic [7:0]       hue;
    logic [RGB_W-1:0] wheel_rgb;
    logic [IDX_W:0]   chase_dist;
    logic [RGB_W-1:0] base;
    logic [RGB_W-1:0] base_q;
    logic [7:0]       bright_s1;

    // Only the low 8 bits of index*spread matter since hue wraps at 256.
    assign hue = phase + 8'(32'(led_index) * 32'(HUE_SPREAD));

    ws2811_color_wheel u_wheel (
        .hue (hue),
        .rgb (wheel_rgb)
    );

    // Distance from the chase head, modulo NUM_LEDS, without a divider.
    always_comb begin
        chase_dist = '0;
        if (led_index >= chase_pos)
            chase_dist = {1'b0, led_index} - {1'b0, chase_pos};
        else
            chase_dist = {1'b0, led_index} + NUM_W - {1'b0, chase_pos};
    end

    always_comb begin
        base = '0;
        case (mode_q)
            MODE_RAINBOW: base = wheel_rgb;
            MODE_SOLID:   base = solid_rgb;
            MODE_CHASE:   base = (chase_dist < CHASE_W) ? solid_rgb : '0;
            default:      base = '0;
        endcase
    end

    // Brightness travels with the colour so a pixel is always scaled by the
    // setting of the frame it belongs to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            base_q    <= '0;
            bright_s1 <= 8'hFF;
        end else begin
            base_q    <= base;
            bright_s1 <= bright_q;
        end
    end

    // ---------------- stage 2: scale and reorder ----------------
    logic [7:0] r_s, g_s, b_s;

    assign r_s = scale8(base_q[23:16], bright_s1);
    assign g_s = scale8(base_q[15:8],  bright_s1);
    assign b_s = scale8(base_q[7:0],   bright_s1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rgb <= '0;
        else if (ORDER == ORDER_GRB)
            rgb <= {g_s, r_s, b_s};
        else
            rgb <= {r_s, g_s, b_s};
    end

endmodule

// File: tb/tb_ws2811_pattern_provider.sv
module tb_ws2811_pattern_provider;

    localparam int NUM = 200;
    localparam int HS  = 1;
    localparam int PS  = 1;
    localparam int CL  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        advance = 1'b0;
    logic        serial_reset = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  brightness = 8'd255;
    logic [23:0] solid_rgb = 24'h0;
    logic [23:0] rgb, rgb_g;
    logic [7:0]  led_index, led_index_g;
    logic        last_led, last_led_g;
    logic [15:0] frame_count, frame_count_g;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    int m_idx = 0, m_phase = 0, m_chase = 0, m_frames = 0;
    int m_mode = 0, m_bright = 255;

    always #10 clock = ~clock;

    ws2811_pattern_provider #(.NUM_LEDS(NUM), .HUE_SPREAD(HS), .PHASE_STEP(PS),
                              .CHASE_LEN(CL), .ORDER(0)) dut (
        .clock(clock), .reset(reset), .advance(advance), .serial_reset(serial_reset),
        .mode(mode), .brightness(brightness), .solid_rgb(solid_rgb),
        .rgb(rgb), .led_index(led_index), .last_led(last_led), .frame_count(frame_count)
    );

    ws2811_pattern_provider #(.NUM_LEDS(NUM), .HUE_SPREAD(HS), .PHASE_STEP(PS),
                              .CHASE_LEN(CL), .ORDER(1)) dut_grb (
        .clock(clock), .reset(reset), .advance(advance), .serial_reset(serial_reset),
        .mode(mode), .brightness(brightness), .solid_rgb(solid_rgb),
        .rgb(rgb_g), .led_index(led_index_g), .last_led(last_led_g), .frame_count(frame_count_g)
    );

    // Expected colour of LED idx from the current model state.
    function automatic logic [23:0] model_rgb(input int idx, input bit grb);
        int h, k, r, g, b, d;
        r = 0; g = 0; b = 0;
        case (m_mode)
            0: begin
                h = (m_phase + idx * HS) % 256;
                if (h < 85)       begin r = 255 - 3*h; g = 3*h; end
                else if (h < 170) begin k = h - 85;  g = 255 - 3*k; b = 3*k; end
                else              begin k = h - 170; r = 3*k; b = 255 - 3*k; end
            end
            1: begin r = int'(solid_rgb[23:16]); g = int'(solid_rgb[15:8]); b = int'(solid_rgb[7:0]); end
            2: begin
                d = (idx - m_chase + NUM) % NUM;
                if (d < CL) begin
                    r = int'(solid_rgb[23:16]); g = int'(solid_rgb[15:8]); b = int'(solid_rgb[7:0]);
                end
            end
            default: ;
        endcase
        r = r * (m_bright + 1) / 256;
        g = g * (m_bright + 1) / 256;
        b = b * (m_bright + 1) / 256;
        return grb ? {8'(g), 8'(r), 8'(b)} : {8'(r), 8'(g), 8'(b)};
    endfunction

    // Stimulus drivers (update the model alongside the pins).
    task automatic adv_pulse(input int w);
        advance = 1'b1;
        repeat (w) @(negedge clock);
        advance = 1'b0;
        if (m_idx < NUM - 1) m_idx++;
        repeat (2) @(negedge clock);
    endtask

    task automatic frame_pulse(input int w);
        serial_reset = 1'b1;
        repeat (w) @(negedge clock);
        serial_reset = 1'b0;
        m_idx    = 0;
        m_phase  = (m_phase + PS) % 256;
        m_chase  = (m_chase + 1) % NUM;
        m_frames = (m_frames + 1) % 65536;
        m_mode   = int'(mode);
        m_bright = int'(brightness);
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++; if (rgb !== 24'h0) begin n_bad++; $display("FAIL reset_rgb got %h want 000000", rgb); end
        n_cmp++; if (led_index !== 8'd0) begin n_bad++; $display("FAIL reset_idx got %0d want 0", led_index); end
        n_cmp++; if (last_led !== 1'b0) begin n_bad++; $display("FAIL reset_last got %b want 0", last_led); end
        n_cmp++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL reset_frame got %0d want 0", frame_count); end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_cmp++; if (rgb !== 24'hFF0000) begin n_bad++; $display("FAIL first_rgb got %h want FF0000", rgb); end
        n_cmp++; if (rgb_g !== 24'h00FF00) begin n_bad++; $display("FAIL first_rgb_grb got %h want 00FF00", rgb_g); end
    endtask

    task automatic test_rainbow_walk;
        logic [23:0] e;
        for (int i = 1; i <= 250; i++) begin
            adv_pulse(($urandom % 4 == 0) ? int'($urandom_range(2, 4)) : 1);
            e = model_rgb(m_idx, 1'b0);
            n_cmp++; if (rgb !== e) begin n_bad++; $display("FAIL walk_rgb step %0d got %h want %h", i, rgb, e); end
            n_cmp++; if (led_index !== 8'(m_idx)) begin n_bad++; $display("FAIL walk_idx step %0d got %0d want %0d", i, led_index, m_idx); end
            n_cmp++; if (last_led !== (m_idx == NUM - 1)) begin n_bad++; $display("FAIL walk_last step %0d got %b", i, last_led); end
            if (i == 85) begin
                n_cmp++; if (rgb !== 24'h00FF00) begin n_bad++; $display("FAIL hue85 got %h want 00FF00", rgb); end
            end
            if (i == 170) begin
                n_cmp++; if (rgb !== 24'h0000FF) begin n_bad++; $display("FAIL hue170 got %h want 0000FF", rgb); end
            end
        end
        n_cmp++; if (led_index !== 8'd199) begin n_bad++; $display("FAIL saturate_idx got %0d want 199", led_index); end
        n_cmp++; if (last_led !== 1'b1) begin n_bad++; $display("FAIL saturate_last got %b want 1", last_led); end
    endtask

    task automatic test_frame;
        frame_pulse(int'($urandom_range(1, 4)));
        n_cmp++; if (led_index !== 8'd0) begin n_bad++; $display("FAIL frame_idx got %0d want 0", led_index); end
        n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL frame_cnt got %0d want 1", frame_count); end
        n_cmp++; if (last_led !== 1'b0) begin n_bad++; $display("FAIL frame_last got %b want 0", last_led); end
        n_cmp++; if (rgb !== 24'hFC0300) begin n_bad++; $display("FAIL frame_rgb got %h want FC0300", rgb); end
        n_cmp++; if (rgb_g !== 24'h03FC00) begin n_bad++; $display("FAIL frame_rgb_grb got %h want 03FC00", rgb_g); end
    endtask

    task automatic test_brightness;
        logic [23:0] e;
        repeat (3) adv_pulse(1);
        brightness = 8'd127;
        adv_pulse(1);
        e = model_rgb(m_idx, 1'b0);
        n_cmp++; if (rgb !== e) begin n_bad++; $display("FAIL bright_hold got %h want %h", rgb, e); end
        frame_pulse(1);
        e = model_rgb(0, 1'b0);
        n_cmp++; if (rgb !== e) begin n_bad++; $display("FAIL bright_apply got %h want %h", rgb, e); end
        // random frames over all modes and brightness levels
        for (int f = 0; f < 8; f++) begin
            mode       = 2'($urandom_range(0, 3));
            brightness = 8'($urandom_range(0, 255));
            solid_rgb  = 24'($urandom);
            if (f == 0) brightness = 8'd0;
            frame_pulse(int'($urandom_range(1, 3)));
            for (int j = 0; j < 6; j++) begin
                e = model_rgb(m_idx, 1'b0);
                n_cmp++; if (rgb !== e) begin n_bad++; $display("FAIL rand_rgb f%0d led %0d got %h want %h", f, m_idx, rgb, e); end
                e = model_rgb(m_idx, 1'b1);
                n_cmp++; if (rgb_g !== e) begin n_bad++; $display("FAIL rand_grb f%0d led %0d got %h want %h", f, m_idx, rgb_g, e); end
                n_cmp++; if (frame_count !== 16'(m_frames)) begin n_bad++; $display("FAIL rand_frame got %0d want %0d", frame_count, m_frames); end
                adv_pulse(int'($urandom_range(1, 3)));
            end
        end
    endtask

    task automatic test_chase;
        logic [23:0] e;
        mode = 2'd2; solid_rgb = 24'h123456; brightness = 8'd255;
        frame_pulse(1);
        while (m_chase != 198) frame_pulse(1);
        for (int i = 0; i < NUM; i++) begin
            if (i > 0) adv_pulse(1);
            e = model_rgb(m_idx, 1'b0);
            n_cmp++; if (rgb !== e) begin n_bad++; $display("FAIL chase_rgb led %0d got %h want %h", m_idx, rgb, e); end
            if (i == 0 || i == 1 || i == 198 || i == 199) begin
                n_cmp++; if (rgb !== 24'h123456) begin n_bad++; $display("FAIL chase_lit led %0d got %h want 123456", i, rgb); end
            end
            if (i == 2) begin
                n_cmp++; if (rgb !== 24'h000000) begin n_bad++; $display("FAIL chase_dark led 2 got %h want 000000", rgb); end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] e;
        int prev;
        mode = 2'd0;
        frame_pulse(1);
        adv_pulse(6);  // long pulse: one step only
        n_cmp++; if (led_index !== 8'd1) begin n_bad++; $display("FAIL long_pulse got %0d want 1", led_index); end
        adv_pulse(1);
        prev = m_frames;
        advance = 1'b1; serial_reset = 1'b1;
        @(negedge clock);
        advance = 1'b0; serial_reset = 1'b0;
        m_idx = 0; m_phase = (m_phase + PS) % 256; m_chase = (m_chase + 1) % NUM;
        m_frames = (m_frames + 1) % 65536; m_mode = int'(mode); m_bright = int'(brightness);
        repeat (3) @(negedge clock);
        n_cmp++; if (led_index !== 8'd0) begin n_bad++; $display("FAIL both_idx got %0d want 0", led_index); end
        n_cmp++; if (frame_count !== 16'(prev + 1)) begin n_bad++; $display("FAIL both_frame got %0d want %0d", frame_count, prev + 1); end
        e = model_rgb(0, 1'b0);
        n_cmp++; if (rgb !== e) begin n_bad++; $display("FAIL both_rgb got %h want %h", rgb, e); end
    endtask

    task automatic test_reset_mid;
        repeat (5) adv_pulse(1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_cmp++; if (rgb !== 24'h0 || rgb_g !== 24'h0) begin n_bad++; $display("FAIL mid_rgb got %h/%h want 0", rgb, rgb_g); end
        n_cmp++; if (led_index !== 8'd0) begin n_bad++; $display("FAIL mid_idx got %0d want 0", led_index); end
        n_cmp++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL mid_frame got %0d want 0", frame_count); end
        n_cmp++; if (last_led !== 1'b0) begin n_bad++; $display("FAIL mid_last got %b want 0", last_led); end
        mode = 2'd1; solid_rgb = 24'hABCDEF;  // ignored until next frame: mode resets to rainbow
        @(negedge clock);
        reset = 1'b1;
        m_idx = 0; m_phase = 0; m_chase = 0; m_frames = 0; m_mode = 0; m_bright = 255;
        repeat (2) @(negedge clock);
        n_cmp++; if (rgb !== 24'hFF0000) begin n_bad++; $display("FAIL mid_release got %h want FF0000", rgb); end
        frame_pulse(1);
        n_cmp++; if (rgb !== model_rgb(0, 1'b0)) begin n_bad++; $display("FAIL mid_solid got %h want ABCDEF", rgb); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_rainbow_walk();
        test_frame();
        test_brightness();
        test_chase();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
